// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle handshaked word-addressed data memory for the MEM stage
module data_mem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              rsp_valid,
  output logic              rsp_wr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]            state;
  logic [3:0]            cnt;
  logic                  pend, hold_wr, hold_err, acc, oor, fire;
  logic [DATA_W-1:0]     hold_rdata;
  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  assign idx       = req_addr[DEPTH_LOG2-1:0];
  assign oor       = |req_addr[ADDR_W-1:DEPTH_LOG2];
  assign req_ready = (state == IDLE) && !flush && rst;
  assign busy      = (state == BUSY);
  assign acc       = req_valid && req_ready;
  // single-cycle builds track the outstanding request with pend instead of the BUSY state
  assign fire      = !flush && ((LATENCY == 1) ? pend : (busy && cnt == 4'(LATENCY)));
  // array write commits at acceptance; read data and request attributes are held until the response
  always_ff @(posedge clk) begin
    if (acc && req_wr && !oor) mem[idx] <= req_wdata;
    if (acc) begin
      hold_rdata <= (req_wr || oor) ? '0 : mem[idx];
      hold_wr    <= req_wr;
      hold_err   <= oor;
    end
  end
  // request lifetime: accept, count to LATENCY, emit one registered response pulse unless flushed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= fire;
      rsp_wr    <= fire && hold_wr;
      rsp_err   <= fire && hold_err;
      rsp_rdata <= fire ? hold_rdata : '0;
      pend      <= acc && (LATENCY == 1);
      state     <= (acc && LATENCY != 1) ? BUSY : (flush || fire) ? IDLE : state;
      cnt       <= acc ? 4'd1 : (busy && !fire && !flush) ? cnt + 4'd1 : '0;
    end
  end
endmodule
